// File: rtl/ebs_regfile_read_sequencer.sv
// ebs_regfile_read_sequencer
//   Owns the four EBS register-file side read ports of the issue stage. It
//   accepts one snapshot request, which is a 32-bit GPR mask plus a tag. Each
//   FETCH cycle reads up to four registers, lowest index first. The fetched
//   values are buffered and then streamed to the EBS sampler as one
//   (addr, data) beat per handshake.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/ready_o     snapshot request handshake (ready only in IDLE)
//   req_mask_i, req_tag_i   GPR mask (bit n = xn) and request tag
//   abort_i                 flush of the current request (ignored in IDLE)
//   ebs_regfile_addr_o      side read addresses (driven only in FETCH)
//   ebs_regfile_data_i      side read data, combinational from the address
//   out_valid_o/ready_i     beat handshake towards the sampler
//   out_addr_o/data_o/tag_o beat contents
//   out_last_o              final beat of the request
//   done_o                  one-cycle completion pulse (not raised on abort)
//   busy_o                  sequencer not idle
module ebs_regfile_read_sequencer #(
  parameter int unsigned NR_PORTS = 4,
  parameter int unsigned XLEN     = 64,
  parameter int unsigned TAG_W    = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic [31:0]                        req_mask_i,
  input  logic [TAG_W-1:0]                   req_tag_i,
  input  logic                               abort_i,
  output logic [NR_PORTS-1:0][4:0]           ebs_regfile_addr_o,
  input  logic [NR_PORTS-1:0][XLEN-1:0]      ebs_regfile_data_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [4:0]                         out_addr_o,
  output logic [XLEN-1:0]                    out_data_o,
  output logic [TAG_W-1:0]                   out_tag_o,
  output logic                               out_last_o,
  output logic                               done_o,
  output logic                               busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t              state_q;
  logic [31:0]         mask_q;
  logic [TAG_W-1:0]    tag_q;
  logic [4:0]          buf_addr_q [NR_PORTS];
  logic [XLEN-1:0]     buf_data_q [NR_PORTS];
  logic [1:0]          rd_ptr_q;
  logic [2:0]          cnt_q;

  logic [NR_PORTS-1:0][4:0] pick_addr;
  logic [31:0]              pick_clr;
  logic [2:0]               pick_cnt;

  // Priority scan from bit 0 upwards: the first NR_PORTS set bits land on
  // ports 0..NR_PORTS-1 in ascending order. Unused ports keep address 0.
  always_comb begin
    pick_addr = '0;
    pick_clr  = '0;
    pick_cnt  = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (mask_q[i] && (pick_cnt < 3'(NR_PORTS))) begin
        pick_addr[pick_cnt[1:0]] = 5'(i);
        pick_clr[i]              = 1'b1;
        pick_cnt                 = pick_cnt + 3'd1;
      end
    end
  end

  assign ebs_regfile_addr_o = (state_q == S_FETCH) ? pick_addr : '0;

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign out_valid_o = (state_q == S_DRAIN) && (cnt_q != 3'd0);
  assign out_addr_o  = buf_addr_q[rd_ptr_q];
  assign out_data_o  = buf_data_q[rd_ptr_q];
  assign out_tag_o   = tag_q;
  // mask_q already has the buffered bits cleared, so it holds only the
  // registers still waiting for a later fetch.
  assign out_last_o  = out_valid_o && (cnt_q == 3'd1) && (mask_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      tag_q    <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned k = 0; k < NR_PORTS; k++) begin
        buf_addr_q[k] <= '0;
        buf_data_q[k] <= '0;
      end
    end else if (abort_i && (state_q != S_IDLE)) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            mask_q  <= req_mask_i;
            tag_q   <= req_tag_i;
            state_q <= (req_mask_i != '0) ? S_FETCH : S_DONE;
          end
        end
        S_FETCH: begin
          for (int unsigned k = 0; k < NR_PORTS; k++) begin
            buf_addr_q[k] <= pick_addr[k];
            buf_data_q[k] <= ebs_regfile_data_i[k];
          end
          cnt_q    <= pick_cnt;
          rd_ptr_q <= '0;
          mask_q   <= mask_q & ~pick_clr;
          state_q  <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_ready_i) begin
            cnt_q    <= cnt_q - 3'd1;
            rd_ptr_q <= rd_ptr_q + 2'd1;
            if (cnt_q == 3'd1) begin
              state_q <= (mask_q != '0) ? S_FETCH : S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ebs_regfile_read_sequencer.sv
module tb_ebs_regfile_read_sequencer;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [31:0]      req_mask_i;
  logic [7:0]       req_tag_i;
  logic             abort_i;
  logic [3:0][4:0]  ebs_regfile_addr_o;
  logic [3:0][63:0] ebs_regfile_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [4:0]       out_addr_o;
  logic [63:0]      out_data_o;
  logic [7:0]       out_tag_o;
  logic             out_last_o;
  logic             done_o;
  logic             busy_o;

  ebs_regfile_read_sequencer #(.NR_PORTS(4), .XLEN(64), .TAG_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_mask_i(req_mask_i), .req_tag_i(req_tag_i), .abort_i(abort_i),
    .ebs_regfile_addr_o(ebs_regfile_addr_o), .ebs_regfile_data_i(ebs_regfile_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o), .out_data_o(out_data_o), .out_tag_o(out_tag_o),
    .out_last_o(out_last_o), .done_o(done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Issue-stage register file: side ports read combinationally.
  logic [63:0] regs [32];
  always_comb begin
    for (int k = 0; k < 4; k++) ebs_regfile_data_i[k] = regs[ebs_regfile_addr_o[k]];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [4:0] a; logic [63:0] d; } beat_t;
  int    pend [$];   // registers requested but not yet read from the ports
  beat_t bufq [$];   // registers read and waiting to be streamed
  bit    m_active, m_fetch, m_done;
  logic [7:0] m_tag;

  // per-request observations used by the directed literal checks
  logic [4:0]  got_a [$];
  logic [63:0] got_d [$];
  bit          got_l [$];
  int acc_cyc, first_cyc, done_cyc, done_seen;
  logic [19:0] first_fetch_addr;

  logic [3:0][4:0] exp_addr;
  bit              exp_valid;
  beat_t           b;

  always @(negedge clk_i) begin
    exp_addr = '0;
    if (m_fetch) for (int k = 0; k < 4 && k < pend.size(); k++) exp_addr[k] = 5'(pend[k]);
    check("fetch_addr", 64'(ebs_regfile_addr_o), 64'(exp_addr));
    exp_valid = m_active && !m_fetch && !m_done && (bufq.size() > 0);
    check("out_valid", 64'(out_valid_o), 64'(exp_valid));
    if (exp_valid && out_valid_o) begin
      check("out_addr", 64'(out_addr_o), 64'(bufq[0].a));
      check("out_data", out_data_o, bufq[0].d);
      check("out_tag", 64'(out_tag_o), 64'(m_tag));
      check("out_last", 64'(out_last_o), 64'((bufq.size() == 1) && (pend.size() == 0)));
    end
    check("done", 64'(done_o), 64'(m_done));
    check("busy", 64'(busy_o), 64'(m_active));
    check("req_ready", 64'(req_ready_o), 64'(!m_active));

    // observations
    if (req_valid_i && req_ready_o && !rst_i) acc_cyc = cyc;
    if (cyc == acc_cyc + 1) first_fetch_addr = ebs_regfile_addr_o;
    if (out_valid_o && first_cyc < 0) first_cyc = cyc;
    if (out_valid_o && out_ready_i) begin
      got_a.push_back(out_addr_o); got_d.push_back(out_data_o); got_l.push_back(out_last_o);
    end
    if (done_o) begin done_seen++; done_cyc = cyc; end

    // advance model by one clock
    if (rst_i || (abort_i && m_active)) begin
      pend.delete(); bufq.delete();
      m_active = 0; m_fetch = 0; m_done = 0;
    end else if (!m_active) begin
      if (req_valid_i) begin
        m_active = 1; m_tag = req_tag_i;
        for (int i = 0; i < 32; i++) if (req_mask_i[i]) pend.push_back(i);
        if (pend.size() == 0) m_done = 1; else m_fetch = 1;
      end
    end else if (m_fetch) begin
      for (int k = 0; k < 4 && pend.size() > 0; k++) begin
        b.a = 5'(pend.pop_front());
        b.d = regs[b.a];
        bufq.push_back(b);
      end
      m_fetch = 0;
    end else if (m_done) begin
      m_done = 0; m_active = 0;
    end else if (out_ready_i) begin
      void'(bufq.pop_front());
      if (bufq.size() == 0) begin
        if (pend.size() > 0) m_fetch = 1; else m_done = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_req(input logic [31:0] m, input logic [7:0] t, input bit ab);
    got_a.delete(); got_d.delete(); got_l.delete();
    first_cyc = -1; done_seen = 0; done_cyc = -1; acc_cyc = -100;
    @(posedge clk_i); #1;
    req_valid_i = 1; req_mask_i = m; req_tag_i = t; abort_i = ab;
    @(posedge clk_i); #1;
    req_valid_i = 0; abort_i = 0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    @(negedge clk_i);
    while (busy_o && n < max_cyc) begin @(negedge clk_i); n++; end
    if (busy_o) begin
      checks++; failures++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", max_cyc);
    end
  endtask

  logic [63:0] old3;
  bit ordered;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = {32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ (32'(i) * 32'h0101_0101)};
    regs[0] = '0;
    rst_i = 1; req_valid_i = 0; req_mask_i = '0; req_tag_i = '0; abort_i = 0; out_ready_i = 1;
    m_active = 0; m_fetch = 0; m_done = 0; m_tag = '0;
    acc_cyc = -100; first_cyc = -1; done_seen = 0; done_cyc = -1; first_fetch_addr = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_addrs", 64'(ebs_regfile_addr_o), 64'd0);
    @(posedge clk_i); #1; rst_i = 0;

    // 1: mask 0xF; x3 rewritten after its fetch must still stream the old value
    start_req(32'h0000_000F, 8'h11, 0);
    old3 = regs[3];
    @(posedge clk_i); #1; regs[3] = 64'hDEAD_BEEF_0000_0003;
    wait_idle(50);
    check("t1_first_valid_lat", 64'(first_cyc - acc_cyc), 64'd2);
    check("t1_done_lat", 64'(done_cyc - acc_cyc), 64'd6);
    check("t1_beats", 64'(got_a.size()), 64'd4);
    if (got_a.size() == 4) begin
      check("t1_addr3", 64'(got_a[3]), 64'd3);
      check("t1_data3_snapshot", got_d[3], old3);
      check("t1_last3", 64'(got_l[3]), 64'd1);
      check("t1_last0", 64'(got_l[0]), 64'd0);
    end
    check("t1_done_count", 64'(done_seen), 64'd1);
    regs[3] = old3;

    // 2: mask 0x8000_0001 -> ports {0,31,0,0}
    start_req(32'h8000_0001, 8'h22, 0);
    wait_idle(50);
    check("t2_fetch_addrs", 64'(first_fetch_addr), 64'h003E0);
    check("t2_beats", 64'(got_a.size()), 64'd2);
    if (got_a.size() == 2) begin
      check("t2_addr1", 64'(got_a[1]), 64'd31);
      check("t2_last1", 64'(got_l[1]), 64'd1);
    end
    check("t2_done_count", 64'(done_seen), 64'd1);

    // 3: all 32 registers; 8 groups of (1 fetch + 4 beats) then DONE at +41
    start_req(32'hFFFF_FFFF, 8'h33, 0);
    wait_idle(100);
    check("t3_beats", 64'(got_a.size()), 64'd32);
    ordered = (got_a.size() == 32);
    for (int i = 0; i < got_a.size(); i++) if (got_a[i] != 5'(i)) ordered = 0;
    check("t3_in_order", 64'(ordered), 64'd1);
    check("t3_done_lat", 64'(done_cyc - acc_cyc), 64'd41);

    // 4: consumer stalls 3 cycles after the first beat
    start_req(32'h0000_00F0, 8'h44, 0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1; out_ready_i = 0;
    repeat (3) @(posedge clk_i);
    #1; out_ready_i = 1;
    wait_idle(50);
    check("t4_beats", 64'(got_a.size()), 64'd4);
    if (got_a.size() == 4) check("t4_addr1", 64'(got_a[1]), 64'd5);
    check("t4_done_lat", 64'(done_cyc - acc_cyc), 64'd9);

    // 5: empty mask
    start_req(32'h0, 8'h55, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    check("t5_ready_back", 64'(req_ready_o), 64'd1);
    check("t5_done_lat", 64'(done_cyc - acc_cyc), 64'd1);
    check("t5_beats", 64'(got_a.size()), 64'd0);

    // 6: abort during second drain of 0xFF (cycle acc+8)
    start_req(32'h0000_00FF, 8'h66, 0);
    repeat (7) @(posedge clk_i);
    #1; abort_i = 1;
    @(posedge clk_i); #1; abort_i = 0;
    @(negedge clk_i);
    check("t6_valid_after_abort", 64'(out_valid_o), 64'd0);
    check("t6_busy_after_abort", 64'(busy_o), 64'd0);
    repeat (6) @(negedge clk_i);
    check("t6_no_done", 64'(done_seen), 64'd0);
    check("t6_beats", 64'(got_a.size()), 64'd6);

    // 7: reset during second drain of 0xFF
    start_req(32'h0000_00FF, 8'h77, 0);
    repeat (7) @(posedge clk_i);
    #1; rst_i = 1;
    @(posedge clk_i); #1; rst_i = 0;
    @(negedge clk_i);
    check("t7_valid_after_rst", 64'(out_valid_o), 64'd0);
    check("t7_ready_after_rst", 64'(req_ready_o), 64'd1);
    repeat (6) @(negedge clk_i);
    check("t7_no_done", 64'(done_seen), 64'd0);

    // 8: abort together with a request in IDLE: request still accepted
    start_req(32'h0000_000C, 8'h88, 1);
    wait_idle(50);
    check("t8_beats", 64'(got_a.size()), 64'd2);
    if (got_a.size() == 2) check("t8_addr0", 64'(got_a[0]), 64'd2);
    check("t8_done_count", 64'(done_seen), 64'd1);

    repeat (2) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
